// File: rtl/tdm_slot_sequencer_if.sv
// Frame handshake and demux-facing signals of the TDM slot sequencer.
interface tdm_slot_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] in_mask;
  logic       yd;
  logic [1:0] t;
  logic       e;
  logic       busy;
  logic       frame_done;

  modport master (
    output in_valid, in_data, in_mask,
    input  in_ready, yd, t, e, busy, frame_done
  );

  modport slave (
    input  in_valid, in_data, in_mask,
    output in_ready, yd, t, e, busy, frame_done
  );
endinterface

// File: rtl/tdm_slot_sequencer.sv
// Serializes a masked 4-bit frame onto a 1-to-4 active-low-enable demux,
// one enabled channel per SLOT_CYCLES-long slot, ascending channel order.
module tdm_slot_sequencer #(
  parameter int unsigned SLOT_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  tdm_slot_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SLOT_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_data;
  logic [3:0]       r_mask;
  logic [1:0]       r_t;
  logic             r_yd;
  logic             r_e;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [3:0]       w_data_nxt;
  logic [3:0]       w_mask_nxt;
  logic [1:0]       w_t_nxt;
  logic             w_yd_nxt;
  logic             w_e_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_in_ready;
  logic             w_accept;
  logic [1:0]       w_first_idx;
  logic [1:0]       w_next_idx;
  logic             w_has_next;

  assign w_in_ready = rst_n && (r_state == ST_IDLE);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Lowest set bit of the offered mask, and next set bit above the current slot.
  always_comb begin
    w_first_idx = 2'd0;
    w_next_idx  = 2'd0;
    w_has_next  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.in_mask[i]) begin
        w_first_idx = 2'(i);
      end
      if (r_mask[i] && (2'(i) > r_t)) begin
        w_has_next = 1'b1;
        w_next_idx = 2'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_mask_nxt  = r_mask;
    w_t_nxt     = r_t;
    w_yd_nxt    = r_yd;
    w_e_nxt     = r_e;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_data_nxt = bus.in_data;
          w_mask_nxt = bus.in_mask;
          if (bus.in_mask == 4'd0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_SLOT;
            w_t_nxt     = w_first_idx;
            w_yd_nxt    = bus.in_data[w_first_idx];
            w_e_nxt     = 1'b0;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = RELOAD;
          end
        end
      end
      ST_SLOT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_has_next) begin
          w_t_nxt   = w_next_idx;
          w_yd_nxt  = r_data[w_next_idx];
          w_cnt_nxt = RELOAD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_t_nxt     = 2'd0;
          w_yd_nxt    = 1'b0;
          w_e_nxt     = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= 4'd0;
      r_mask  <= 4'd0;
      r_t     <= 2'd0;
      r_yd    <= 1'b0;
      r_e     <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
      r_t     <= w_t_nxt;
      r_yd    <= w_yd_nxt;
      r_e     <= w_e_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.yd         = r_yd;
  assign bus.t          = r_t;
  assign bus.e          = r_e;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// Randomized + directed scoreboard bench for tdm_slot_sequencer.
module tb_tdm_slot_sequencer;

  localparam int unsigned SC = 3;

  typedef struct {
    bit         done;
    logic [1:0] t;
    logic       yd;
  } exp_t;

  logic clk;
  logic rst_n;
  tdm_slot_sequencer_if bus ();

  tdm_slot_sequencer #(.SLOT_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  bit   pend;
  bit   last_acc;
  logic [3:0] pend_data;
  logic [3:0] pend_mask;

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected output stream of one frame: SC cycles per set channel, ascending, then done.
  task automatic push_frame(input logic [3:0] d, input logic [3:0] m);
    exp_t it;
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int k = 0; k < int'(SC); k++) begin
          it.done = 1'b0;
          it.t    = 2'(ch);
          it.yd   = d[ch];
          exp_q.push_back(it);
        end
      end
    end
    it.done = 1'b1;
    it.t    = 2'd0;
    it.yd   = 1'b0;
    exp_q.push_back(it);
  endtask

  // One clock: decide acceptance from pre-edge inputs, update model at the edge.
  task automatic tick();
    #1;
    pend      = rst_n && bus.in_valid && bus.in_ready;
    pend_data = bus.in_data;
    pend_mask = bus.in_mask;
    @(posedge clk);
    if (!rst_n) exp_q.delete();
    if (pend) push_frame(pend_data, pend_mask);
    last_acc = pend;
    #1;
  endtask

  task automatic send_hold(input logic [3:0] d, input logic [3:0] m, input int n);
    int got = 0;
    int budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mask  = m;
    while (got < n && budget < 200) begin
      tick();
      if (last_acc) got++;
      budget++;
    end
    bus.in_valid = 1'b0;
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=%0d exp=%0d", got, n);
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    tick();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
    end
  endtask

  // Monitor: every cycle the DUT must present exactly the next expected item, or be idle.
  always @(negedge clk) begin
    exp_t it;
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        if (it.done) begin
          chk("done_pulse", 4'(bus.frame_done), 4'd1);
          chk("done_e",     4'(bus.e),          4'd1);
          chk("done_t",     4'(bus.t),          4'd0);
          chk("done_yd",    4'(bus.yd),         4'd0);
          chk("done_busy",  4'(bus.busy),       4'd0);
        end else begin
          chk("slot_e",     4'(bus.e),          4'd0);
          chk("slot_busy",  4'(bus.busy),       4'd1);
          chk("slot_done",  4'(bus.frame_done), 4'd0);
          chk("slot_t",     4'(bus.t),          4'(it.t));
          chk("slot_yd",    4'(bus.yd),         4'(it.yd));
        end
      end else begin
        chk("idle_e",    4'(bus.e),          4'd1);
        chk("idle_busy", 4'(bus.busy),       4'd0);
        chk("idle_done", 4'(bus.frame_done), 4'd0);
        chk("idle_t",    4'(bus.t),          4'd0);
        chk("idle_yd",   4'(bus.yd),         4'd0);
      end
      chk("in_ready", 4'(bus.in_ready), 4'(rst_n && (exp_q.size() == 0)));
    end
  end

  initial begin
    logic [3:0] d;
    logic [3:0] m;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'd0;
    bus.in_mask  = 4'd0;
    tick();
    tick();
    mon_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // All four channels, alternating data.
    send_hold(4'b1010, 4'b1111, 1);
    wait_idle();
    // Sparse mask skips channels 1 and 3.
    send_hold(4'b0100, 4'b0101, 1);
    wait_idle();
    // Zero-mask frames accepted every cycle.
    send_hold(4'b1111, 4'b0000, 3);
    wait_idle();
    // Back-to-back single-channel frames with valid held.
    send_hold(4'b1000, 4'b1000, 2);
    wait_idle();
    // Input changes and valid pulses while busy must not disturb the frame.
    send_hold(4'b0110, 4'b0111, 1);
    bus.in_data = 4'b1001;
    bus.in_mask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = i[0];
      tick();
    end
    bus.in_valid = 1'b0;
    wait_idle();
    // Reset during slot 2 of a four-slot frame, then a clean restart.
    send_hold(4'b1111, 4'b1111, 1);
    for (int i = 0; i < int'(SC) + 1; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_hold(4'b0011, 4'b1111, 1);
    wait_idle();

    // Random frames with random gaps, busy-time offers and occasional resets.
    for (int n = 0; n < 60; n++) begin
      d = 4'($urandom);
      m = 4'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        rst_n = 1'b1;
      end
      send_hold(d, m, int'($urandom_range(1, 2)));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
